wbsp2axlite: RTL and testbench

WBSP2AXLITE -- requirements
Module: wbsp2axlite

---
 rtl/wbsp2axlite.sv | 193 +++++++++++++++++++
 tb/tb_wbsp2axlite.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbsp2axlite.sv
// Wishbone pipelined slave to AXI4-lite master bridge.
// Accepts one Wishbone request at a time and runs it as a single AXI4-lite
// read or write. The bridge stalls Wishbone until the AXI response returns.
// It then answers with a one-cycle ack (OKAY/EXOKAY) or err (SLVERR/DECERR).
module wbsp2axlite #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned AW               = C_AXI_ADDR_WIDTH - 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // Wishbone pipelined slave
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [AW-1:0]               wb_adr_i,
  input  logic [C_AXI_DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]                  wb_sel_i,
  output logic                        wb_stall_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic [C_AXI_DATA_WIDTH-1:0] wb_dat_o,
  // AXI4-lite write address channel
  output logic                        o_axi_awvalid,
  input  logic                        i_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic [2:0]                  o_axi_awprot,
  // AXI4-lite write data channel
  output logic                        o_axi_wvalid,
  input  logic                        i_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0] o_axi_wdata,
  output logic [3:0]                  o_axi_wstrb,
  // AXI4-lite write response channel
  input  logic                        i_axi_bvalid,
  output logic                        o_axi_bready,
  input  logic [1:0]                  i_axi_bresp,
  // AXI4-lite read address channel
  output logic                        o_axi_arvalid,
  input  logic                        i_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
  output logic [2:0]                  o_axi_arprot,
  // AXI4-lite read data channel
  input  logic                        i_axi_rvalid,
  output logic                        o_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]                  i_axi_rresp
);

  localparam int unsigned DW = C_AXI_DATA_WIDTH;
  localparam int unsigned BAW = AW + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RA   = 3'd3,
    S_RD   = 3'd4
  } state_t;

  state_t          state;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [3:0]      sel_q;
  // Set once the master abandons the cycle; the answer is then swallowed.
  logic            aborted;

  logic            aw_pend;
  logic            w_pend;
  logic            b_hs;
  logic            r_hs;
  logic            wb_live;
  logic [BAW-1:0]  byte_adr;
  logic            unused_resp;

  // Valid still outstanding after this cycle's handshake on each write channel
  assign aw_pend  = o_axi_awvalid & ~i_axi_awready;
  assign w_pend   = o_axi_wvalid  & ~i_axi_wready;
  assign b_hs     = i_axi_bvalid  & o_axi_bready;
  assign r_hs     = i_axi_rvalid  & o_axi_rready;
  // Master still wants an answer for the transaction in flight
  assign wb_live  = wb_cyc_i & ~aborted;
  assign byte_adr = {adr_q, 2'b00};

  // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR
  assign unused_resp = &{1'b0, i_axi_bresp[0], i_axi_rresp[0]};

  // Request payload is held in registers; AXI payload is a direct view of it
  assign o_axi_awaddr = C_AXI_ADDR_WIDTH'(byte_adr);
  assign o_axi_araddr = C_AXI_ADDR_WIDTH'(byte_adr);
  assign o_axi_awprot = 3'b000;
  assign o_axi_arprot = 3'b000;
  assign o_axi_wdata  = dat_q;
  assign o_axi_wstrb  = sel_q;

  // Bridge FSM with registered handshake and completion outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      aborted       <= 1'b0;
      wb_stall_o    <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      wb_dat_o      <= '0;
      o_axi_awvalid <= 1'b0;
      o_axi_wvalid  <= 1'b0;
      o_axi_bready  <= 1'b0;
      o_axi_arvalid <= 1'b0;
      o_axi_rready  <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            adr_q      <= wb_adr_i;
            dat_q      <= wb_dat_i;
            sel_q      <= wb_sel_i;
            aborted    <= 1'b0;
            wb_stall_o <= 1'b1;
            if (wb_we_i) begin
              state         <= S_WR;
              o_axi_awvalid <= 1'b1;
              o_axi_wvalid  <= 1'b1;
            end else begin
              state         <= S_RA;
              o_axi_arvalid <= 1'b1;
            end
          end
        end

        S_WR: begin
          // AW and W retire independently; move on once neither is pending
          o_axi_awvalid <= aw_pend;
          o_axi_wvalid  <= w_pend;
          if (!aw_pend && !w_pend) begin
            state        <= S_WB;
            o_axi_bready <= 1'b1;
          end
        end

        S_WB: begin
          if (b_hs) begin
            state        <= S_IDLE;
            o_axi_bready <= 1'b0;
            wb_stall_o   <= 1'b0;
            wb_ack_o     <= wb_live & ~i_axi_bresp[1];
            wb_err_o     <= wb_live &  i_axi_bresp[1];
          end
        end

        S_RA: begin
          if (i_axi_arready) begin
            state         <= S_RD;
            o_axi_arvalid <= 1'b0;
            o_axi_rready  <= 1'b1;
          end
        end

        S_RD: begin
          if (r_hs) begin
            state        <= S_IDLE;
            o_axi_rready <= 1'b0;
            wb_stall_o   <= 1'b0;
            wb_dat_o     <= i_axi_rdata;
            wb_ack_o     <= wb_live & ~i_axi_rresp[1];
            wb_err_o     <= wb_live &  i_axi_rresp[1];
          end
        end

        default: begin
          state         <= S_IDLE;
          wb_stall_o    <= 1'b0;
          o_axi_awvalid <= 1'b0;
          o_axi_wvalid  <= 1'b0;
          o_axi_bready  <= 1'b0;
          o_axi_arvalid <= 1'b0;
          o_axi_rready  <= 1'b0;
        end
      endcase

      // Remember a dropped cycle for the rest of the transaction
      if (state != S_IDLE && !wb_cyc_i) begin
        aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wbsp2axlite.sv
// Directed testbench for the Wishbone-to-AXI4-lite bridge.
module tb_wbsp2axlite;

  logic        clk_i;
  logic        rst_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [29:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;
  logic        o_axi_awvalid;
  logic        i_axi_awready;
  logic [31:0] o_axi_awaddr;
  logic [2:0]  o_axi_awprot;
  logic        o_axi_wvalid;
  logic        i_axi_wready;
  logic [31:0] o_axi_wdata;
  logic [3:0]  o_axi_wstrb;
  logic        i_axi_bvalid;
  logic        o_axi_bready;
  logic [1:0]  i_axi_bresp;
  logic        o_axi_arvalid;
  logic        i_axi_arready;
  logic [31:0] o_axi_araddr;
  logic [2:0]  o_axi_arprot;
  logic        i_axi_rvalid;
  logic        o_axi_rready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;

  int n_chk;
  int n_fail;

  // {stall, awvalid, wvalid, bready, arvalid, rready, ack, err}
  logic [7:0] ctl;
  assign ctl = {wb_stall_o, o_axi_awvalid, o_axi_wvalid, o_axi_bready,
                o_axi_arvalid, o_axi_rready, wb_ack_o, wb_err_o};

  wbsp2axlite dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_stall_o    (wb_stall_o),
    .wb_ack_o      (wb_ack_o),
    .wb_err_o      (wb_err_o),
    .wb_dat_o      (wb_dat_o),
    .o_axi_awvalid (o_axi_awvalid),
    .i_axi_awready (i_axi_awready),
    .o_axi_awaddr  (o_axi_awaddr),
    .o_axi_awprot  (o_axi_awprot),
    .o_axi_wvalid  (o_axi_wvalid),
    .i_axi_wready  (i_axi_wready),
    .o_axi_wdata   (o_axi_wdata),
    .o_axi_wstrb   (o_axi_wstrb),
    .i_axi_bvalid  (i_axi_bvalid),
    .o_axi_bready  (o_axi_bready),
    .i_axi_bresp   (i_axi_bresp),
    .o_axi_arvalid (o_axi_arvalid),
    .i_axi_arready (i_axi_arready),
    .o_axi_araddr  (o_axi_araddr),
    .o_axi_arprot  (o_axi_arprot),
    .i_axi_rvalid  (i_axi_rvalid),
    .o_axi_rready  (o_axi_rready),
    .i_axi_rdata   (i_axi_rdata),
    .i_axi_rresp   (i_axi_rresp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_req(input logic we, input logic [29:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if (ctl !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 8'h00);
    end
    n_chk++;
    if ({wb_dat_o, o_axi_awaddr, o_axi_wdata, o_axi_wstrb} !== 100'd0) begin
      n_fail++; $display("FAIL reset_regs: dat_o=%h awaddr=%h wdata=%h wstrb=%h want all 0",
                         wb_dat_o, o_axi_awaddr, o_axi_wdata, o_axi_wstrb);
    end
    n_chk++;
    if ({o_axi_awprot, o_axi_arprot} !== 6'd0) begin
      n_fail++; $display("FAIL reset_prot: got %b want 0", {o_axi_awprot, o_axi_arprot});
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_write_basic();
    drive_req(1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
    n_chk++;
    if (ctl !== 8'b0000_0000) begin
      n_fail++; $display("FAIL wr_idle: got %b want %b", ctl, 8'b0000_0000);
    end
    tick();
    wb_stb_i = 1'b0;
    n_chk++;
    if (ctl !== 8'b1110_0000) begin
      n_fail++; $display("FAIL wr_issue: got %b want %b", ctl, 8'b1110_0000);
    end
    n_chk++;
    if ({o_axi_awaddr, o_axi_wdata, o_axi_wstrb} !== {32'h40, 32'hDEADBEEF, 4'hF}) begin
      n_fail++; $display("FAIL wr_payload: awaddr=%h wdata=%h wstrb=%h want 00000040 deadbeef f",
                         o_axi_awaddr, o_axi_wdata, o_axi_wstrb);
    end
    i_axi_awready = 1'b1;
    i_axi_wready  = 1'b1;
    tick();
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    n_chk++;
    if (ctl !== 8'b1001_0000) begin
      n_fail++; $display("FAIL wr_to_wb: got %b want %b", ctl, 8'b1001_0000);
    end
    i_axi_bvalid = 1'b1;
    i_axi_bresp  = 2'b00;
    tick();
    i_axi_bvalid = 1'b0;
    n_chk++;
    if (ctl !== 8'b0000_0010) begin
      n_fail++; $display("FAIL wr_ack: got %b want %b", ctl, 8'b0000_0010);
    end
    tick();
    n_chk++;
    if (ctl !== 8'b0000_0000) begin
      n_fail++; $display("FAIL wr_ack_single: got %b want %b", ctl, 8'b0000_0000);
    end
  endtask

  task automatic test_read_delayed();
    drive_req(1'b0, 30'h3, 32'h0, 4'h0);
    tick();
    wb_stb_i = 1'b0;
    n_chk++;
    if (ctl !== 8'b1000_1000 || o_axi_araddr !== 32'hC) begin
      n_fail++; $display("FAIL rd_issue: ctl=%b araddr=%h want %b 0000000c",
                         ctl, o_axi_araddr, 8'b1000_1000);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (ctl !== 8'b1000_1000) begin
        n_fail++; $display("FAIL rd_ar_wait%0d: got %b want %b", i, ctl, 8'b1000_1000);
      end
    end
    i_axi_arready = 1'b1;
    tick();
    i_axi_arready = 1'b0;
    n_chk++;
    if (ctl !== 8'b1000_0100) begin
      n_fail++; $display("FAIL rd_to_rd: got %b want %b", ctl, 8'b1000_0100);
    end
    i_axi_rvalid = 1'b1;
    i_axi_rdata  = 32'h12345678;
    i_axi_rresp  = 2'b00;
    tick();
    i_axi_rvalid = 1'b0;
    i_axi_rdata  = 32'hFFFF0000;
    n_chk++;
    if (ctl !== 8'b0000_0010 || wb_dat_o !== 32'h12345678) begin
      n_fail++; $display("FAIL rd_ack: ctl=%b dat=%h want %b 12345678",
                         ctl, wb_dat_o, 8'b0000_0010);
    end
    tick();
    n_chk++;
    if (ctl !== 8'b0000_0000 || wb_dat_o !== 32'h12345678) begin
      n_fail++; $display("FAIL rd_hold: ctl=%b dat=%h want %b 12345678",
                         ctl, wb_dat_o, 8'b0000_0000);
    end
  endtask

  task automatic test_write_split_err();
    drive_req(1'b1, 30'h20, 32'hCAFEF00D, 4'h3);
    tick();
    wb_stb_i = 1'b0;
    i_axi_awready = 1'b1;
    tick();
    i_axi_awready = 1'b0;
    n_chk++;
    if (ctl !== 8'b1010_0000) begin
      n_fail++; $display("FAIL wsplit_aw_done: got %b want %b", ctl, 8'b1010_0000);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (ctl !== 8'b1010_0000 || o_axi_wdata !== 32'hCAFEF00D || o_axi_wstrb !== 4'h3) begin
        n_fail++; $display("FAIL wsplit_w_hold%0d: ctl=%b wdata=%h wstrb=%h want %b cafef00d 3",
                           i, ctl, o_axi_wdata, o_axi_wstrb, 8'b1010_0000);
      end
    end
    i_axi_wready = 1'b1;
    tick();
    i_axi_wready = 1'b0;
    n_chk++;
    if (ctl !== 8'b1001_0000) begin
      n_fail++; $display("FAIL wsplit_to_wb: got %b want %b", ctl, 8'b1001_0000);
    end
    i_axi_bvalid = 1'b1;
    i_axi_bresp  = 2'b10;
    tick();
    i_axi_bvalid = 1'b0;
    i_axi_bresp  = 2'b00;
    n_chk++;
    if (ctl !== 8'b0000_0001) begin
      n_fail++; $display("FAIL wsplit_err: got %b want %b", ctl, 8'b0000_0001);
    end
    tick();
    n_chk++;
    if (ctl !== 8'b0000_0000) begin
      n_fail++; $display("FAIL wsplit_err_single: got %b want %b", ctl, 8'b0000_0000);
    end
  endtask

  task automatic test_read_err();
    drive_req(1'b0, 30'h5, 32'h0, 4'h0);
    tick();
    wb_stb_i = 1'b0;
    i_axi_arready = 1'b1;
    tick();
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b1;
    i_axi_rdata   = 32'hA5A55A5A;
    i_axi_rresp   = 2'b11;
    tick();
    i_axi_rvalid = 1'b0;
    i_axi_rresp  = 2'b00;
    n_chk++;
    if (ctl !== 8'b0000_0001 || wb_dat_o !== 32'hA5A55A5A) begin
      n_fail++; $display("FAIL rerr: ctl=%b dat=%h want %b a5a55a5a",
                         ctl, wb_dat_o, 8'b0000_0001);
    end
    tick();
    n_chk++;
    if (ctl !== 8'b0000_0000) begin
      n_fail++; $display("FAIL rerr_single: got %b want %b", ctl, 8'b0000_0000);
    end
  endtask

  task automatic test_cyc_drop();
    drive_req(1'b1, 30'h7, 32'h01020304, 4'hF);
    tick();
    wb_stb_i = 1'b0;
    i_axi_awready = 1'b1;
    i_axi_wready  = 1'b1;
    tick();
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    wb_cyc_i = 1'b0;
    tick();
    n_chk++;
    if (ctl !== 8'b1001_0000) begin
      n_fail++; $display("FAIL drop_wb_wait: got %b want %b", ctl, 8'b1001_0000);
    end
    i_axi_bvalid = 1'b1;
    tick();
    i_axi_bvalid = 1'b0;
    n_chk++;
    if (ctl !== 8'b0000_0000) begin
      n_fail++; $display("FAIL drop_no_ack: got %b want %b", ctl, 8'b0000_0000);
    end
    drive_req(1'b0, 30'h1, 32'h0, 4'h0);
    tick();
    wb_stb_i = 1'b0;
    n_chk++;
    if (ctl !== 8'b1000_1000 || o_axi_araddr !== 32'h4) begin
      n_fail++; $display("FAIL drop_next_issue: ctl=%b araddr=%h want %b 00000004",
                         ctl, o_axi_araddr, 8'b1000_1000);
    end
    i_axi_arready = 1'b1;
    tick();
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b1;
    i_axi_rdata   = 32'h11223344;
    tick();
    i_axi_rvalid = 1'b0;
    n_chk++;
    if (ctl !== 8'b0000_0010 || wb_dat_o !== 32'h11223344) begin
      n_fail++; $display("FAIL drop_next_ack: ctl=%b dat=%h want %b 11223344",
                         ctl, wb_dat_o, 8'b0000_0010);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // stb stays high with a read request while the write is stalled
    drive_req(1'b1, 30'h30, 32'h55AA55AA, 4'hC);
    tick();
    drive_req(1'b0, 30'h31, 32'h0, 4'h0);
    i_axi_awready = 1'b1;
    i_axi_wready  = 1'b1;
    tick();
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    n_chk++;
    if (ctl !== 8'b1001_0000 || o_axi_awaddr !== 32'hC0 || o_axi_wstrb !== 4'hC) begin
      n_fail++; $display("FAIL b2b_stall_ignored: ctl=%b awaddr=%h wstrb=%h want %b 000000c0 c",
                         ctl, o_axi_awaddr, o_axi_wstrb, 8'b1001_0000);
    end
    i_axi_bvalid = 1'b1;
    tick();
    i_axi_bvalid = 1'b0;
    n_chk++;
    if (ctl !== 8'b0000_0010) begin
      n_fail++; $display("FAIL b2b_wr_ack: got %b want %b", ctl, 8'b0000_0010);
    end
    tick();
    wb_stb_i = 1'b0;
    n_chk++;
    if (ctl !== 8'b1000_1000 || o_axi_araddr !== 32'hC4) begin
      n_fail++; $display("FAIL b2b_rd_issue: ctl=%b araddr=%h want %b 000000c4",
                         ctl, o_axi_araddr, 8'b1000_1000);
    end
    i_axi_arready = 1'b1;
    tick();
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b1;
    i_axi_rdata   = 32'h0BADF00D;
    tick();
    i_axi_rvalid = 1'b0;
    n_chk++;
    if (ctl !== 8'b0000_0010 || wb_dat_o !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL b2b_rd_ack: ctl=%b dat=%h want %b 0badf00d",
                         ctl, wb_dat_o, 8'b0000_0010);
    end
    tick();
  endtask

  task automatic test_reset_in_rd();
    drive_req(1'b0, 30'h2, 32'h0, 4'h0);
    tick();
    wb_stb_i = 1'b0;
    i_axi_arready = 1'b1;
    tick();
    i_axi_arready = 1'b0;
    n_chk++;
    if (ctl !== 8'b1000_0100) begin
      n_fail++; $display("FAIL rst_rd_state: got %b want %b", ctl, 8'b1000_0100);
    end
    rst_i = 1'b1;
    #1;
    n_chk++;
    if (ctl !== 8'b0000_0000 || wb_dat_o !== 32'h0 || o_axi_araddr !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: ctl=%b dat=%h araddr=%h want 0 0 0",
                         ctl, wb_dat_o, o_axi_araddr);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    i_axi_rvalid = 1'b1;
    i_axi_rdata  = 32'h77777777;
    tick();
    i_axi_rvalid = 1'b0;
    n_chk++;
    if (ctl !== 8'b0000_0000 || wb_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_idle: ctl=%b dat=%h want %b 0", ctl, wb_dat_o, 8'b0000_0000);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_i  = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    i_axi_bvalid  = 1'b0;
    i_axi_bresp   = 2'b00;
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b0;
    i_axi_rdata   = '0;
    i_axi_rresp   = 2'b00;

    test_reset();
    test_write_basic();
    test_read_delayed();
    test_write_split_err();
    test_read_err();
    test_cyc_drop();
    test_back_to_back();
    test_reset_in_rd();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
